// File: rtl/pft_pkg.sv
// Shared state encoding, array geometry and helpers for the PFT BRAM sequencer.
package pft_pkg;
   localparam int ADDR_W     = 5;
   localparam int DATA_W     = 8;
   localparam int PE_COLS    = 16;
   localparam int NBANK      = 32;
   localparam int RD_LAT_DEF = 1;
   localparam logic [7:0] PAD_VAL = 8'h80;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SWEEP,
      ST_CENT,
      ST_DRAIN
   } state_t;

   // Terminal counter value for a count config; a zero config behaves as one.
   function automatic logic [5:0] cfg_last(input logic [5:0] v);
      return (v == 6'd0) ? 6'd0 : v - 6'd1;
   endfunction
endpackage

// File: rtl/pft_rd_pipe.sv
// RD_LAT-deep shift of {valid,last} so read strobes line up with BRAM data return.
// Fixed RD_LAT-cycle latency; no backpressure, shifts every cycle.
module pft_rd_pipe #(
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_vld,
   input  logic in_last,
   output logic out_vld,
   output logic out_last
);
   logic [RD_LAT-1:0] vld_q, vld_d, last_q, last_d;

   always_comb begin
      vld_d     = vld_q;
      last_d    = last_q;
      vld_d[0]  = in_vld;
      last_d[0] = in_last;
      for (int i = 1; i < RD_LAT; i++) begin
         vld_d[i]  = vld_q[i-1];
         last_d[i] = last_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         last_q <= '0;
      end else begin
         vld_q  <= vld_d;
         last_q <= last_d;
      end
   end

   assign out_vld  = vld_q[RD_LAT-1];
   assign out_last = vld_q[RD_LAT-1] & last_q[RD_LAT-1];
endmodule

// File: rtl/pft_bram_ctrl.sv
// Load/sweep/centroid sequencer for the banked PFT BRAM array; all array pins registered,
// writes land 1 cycle after the load handshake, read data is flagged RD_LAT cycles after issue.
module pft_bram_ctrl
   import pft_pkg::*;
#(
   parameter int PFT_addr_width = ADDR_W,
   parameter int PFT_data_width = DATA_W,
   parameter int PE_COL         = PE_COLS,
   parameter int PFT_bank       = NBANK,
   parameter int RD_LAT         = RD_LAT_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [5:0]                           cfg_nbank,
   input  logic [5:0]                           cfg_depth,
   input  logic                                 load_start,
   input  logic                                 load_valid,
   output logic                                 load_ready,
   input  logic [PFT_data_width*PE_COL-1:0]     load_data,
   input  logic                                 sweep_start,
   input  logic                                 cent_start,
   input  logic [4:0]                           cent_bank,
   input  logic [4:0]                           cent_addr,
   output logic [PFT_bank-1:0]                  pft_write,
   output logic [PFT_addr_width-1:0]            pft_waddr,
   output logic [PFT_data_width*PE_COL-1:0]     pft_din,
   output logic [PFT_addr_width*PFT_bank-1:0]   pft_raddr,
   output logic [PFT_bank-1:0]                  pft_valid,
   output logic                                 pft_is_centroid,
   output logic                                 out_valid,
   output logic                                 out_last,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err
);
   localparam int W  = PFT_data_width * PE_COL;
   localparam int AW = PFT_addr_width;

   state_t                   state_q, state_d;
   logic [5:0]               a_q, a_d, b_q, b_d, r_q, r_d, r_inc;
   logic [5:0]               nbank_last_q, nbank_last_d, depth_last_q, depth_last_d;
   logic [PFT_bank-1:0]      filled_q, filled_d, write_q, write_d, valid_q, valid_d;
   logic [4:0]               cbank_q, cbank_d;
   logic [AW-1:0]            waddr_q, waddr_d;
   logic [W-1:0]             din_q, din_d;
   logic [AW*PFT_bank-1:0]   raddr_q, raddr_d;
   logic                     cent_q, cent_d, iss_vld_q, iss_vld_d, iss_last_q, iss_last_d;
   logic                     done_q, done_d, err_q, err_d;

   assign r_inc = r_q + 6'd1;

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      r_d          = r_q;
      nbank_last_d = nbank_last_q;
      depth_last_d = depth_last_q;
      filled_d     = filled_q;
      cbank_d      = cbank_q;
      write_d      = '0;
      waddr_d      = waddr_q;
      din_d        = din_q;
      raddr_d      = raddr_q;
      cent_d       = cent_q;
      iss_vld_d    = 1'b0;
      iss_last_d   = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               nbank_last_d = cfg_last(cfg_nbank);
               depth_last_d = cfg_last(cfg_depth);
               filled_d     = '0;
               a_d          = '0;
               b_d          = '0;
               state_d      = ST_LOAD;
            end else if (sweep_start) begin
               // Nothing loaded: finish at once without touching the array.
               if (filled_q == '0) begin
                  done_d = 1'b1;
               end else begin
                  depth_last_d = cfg_last(cfg_depth);
                  r_d          = '0;
                  raddr_d      = '0;
                  iss_vld_d    = 1'b1;
                  iss_last_d   = (cfg_last(cfg_depth) == 6'd0);
                  state_d      = ST_SWEEP;
               end
            end else if (cent_start) begin
               if (!filled_q[cent_bank]) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  cbank_d = cent_bank;
                  raddr_d[cent_bank*AW +: AW] = AW'(cent_addr);
                  cent_d     = 1'b1;
                  iss_vld_d  = 1'b1;
                  iss_last_d = 1'b1;
                  state_d    = ST_CENT;
               end
            end
         end
         ST_LOAD: begin
            if (load_valid) begin
               write_d = PFT_bank'(1) << b_q;
               waddr_d = a_q[AW-1:0];
               din_d   = load_data;
               if (a_q == depth_last_q) begin
                  a_d = '0;
                  filled_d[b_q[4:0]] = 1'b1;
                  if (b_q == nbank_last_q) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     b_d = b_q + 6'd1;
                  end
               end else begin
                  a_d = a_q + 6'd1;
               end
            end
         end
         ST_SWEEP: begin
            if (r_q == depth_last_q) begin
               state_d = ST_DRAIN;
            end else begin
               r_d        = r_inc;
               raddr_d    = {PFT_bank{r_inc[AW-1:0]}};
               iss_vld_d  = 1'b1;
               iss_last_d = (r_inc == depth_last_q);
            end
         end
         ST_CENT: state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (out_last) begin
               state_d = ST_IDLE;
               cent_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Array sees the filled mask except while a centroid read owns it.
      valid_d = cent_d ? (PFT_bank'(1) << cbank_d) : filled_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         r_q          <= '0;
         nbank_last_q <= '0;
         depth_last_q <= '0;
         filled_q     <= '0;
         cbank_q      <= '0;
         write_q      <= '0;
         waddr_q      <= '0;
         din_q        <= '0;
         raddr_q      <= '0;
         valid_q      <= '0;
         cent_q       <= 1'b0;
         iss_vld_q    <= 1'b0;
         iss_last_q   <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         r_q          <= r_d;
         nbank_last_q <= nbank_last_d;
         depth_last_q <= depth_last_d;
         filled_q     <= filled_d;
         cbank_q      <= cbank_d;
         write_q      <= write_d;
         waddr_q      <= waddr_d;
         din_q        <= din_d;
         raddr_q      <= raddr_d;
         valid_q      <= valid_d;
         cent_q       <= cent_d;
         iss_vld_q    <= iss_vld_d;
         iss_last_q   <= iss_last_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   pft_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (iss_vld_q),
      .in_last  (iss_last_q),
      .out_vld  (out_valid),
      .out_last (out_last)
   );

   assign load_ready      = (state_q == ST_LOAD);
   assign busy            = (state_q != ST_IDLE);
   assign pft_write       = write_q;
   assign pft_waddr       = waddr_q;
   assign pft_din         = din_q;
   assign pft_raddr       = raddr_q;
   assign pft_valid       = valid_q;
   assign pft_is_centroid = cent_q;
   assign err             = err_q;
   // Read operations end on the final returned word, the rest on a registered pulse.
   assign done            = done_q | out_last;
endmodule
